lift_occupancy_counter: RTL and testbench
=========================================

LIFT_OCCUPANCY_COUNTER -- requirements
Module: lift_occupancy_counter

Interface
REQ-001 SHALL have parameter CAPACITY, default 8: maximum occupancy, integer 1..(2^CNT_W)-1.
REQ-002 SHALL have parameter CNT_W, default 4: COUNT width, at least clog2(CAPACITY+1).
REQ-003 SHALL have parameter NEAR_FULL, default 6: NearFull threshold, integer 0..CAPACITY.
REQ-004 SHALL have parameter DEBOUNCE, default 3: consecutive synchronized samples required to accept a sensor level, at least 1.
REQ-005 SHALL have port CLK  input  1  sole clock, all state updates on its rising edge.
REQ-006 SHALL have port RST  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port SI  input  1  entry sensor, asynchronous level, high while a person passes in.
REQ-008 SHALL have port SO  input  1  exit sensor, asynchronous level, high while a person passes out.
REQ-009 SHALL have port COUNT  output  CNT_W  current occupancy, registered.
REQ-010 SHALL have port Full  output  1  high iff COUNT == CAPACITY, registered.
REQ-011 SHALL have port Empty  output  1  high iff COUNT == 0, registered.
REQ-012 SHALL have port NearFull  output  1  high iff COUNT >= NEAR_FULL, registered.
REQ-013 SHALL have port Reject  output  1  one-cycle pulse: entry accepted while full.
REQ-014 SHALL have port Underflow  output  1  one-cycle pulse: exit accepted while empty.

Function
REQ-015 SHALL pass SI and SO each through a 2-flop synchronizer; the sampled value s is the 2nd flop output.
REQ-016 SHALL run one debounce FSM per channel, states IDLE, ARM, HELD, with a counter of width clog2(DEBOUNCE+1).
REQ-017 IDLE: s=1 -> ARM with counter=1; s=0 -> stay.
REQ-018 ARM: s=0 -> IDLE; s=1 and counter==DEBOUNCE -> HELD and issue a one-cycle event; otherwise increment the counter.
REQ-019 HELD: count consecutive s=0 samples; on reaching DEBOUNCE -> IDLE; any s=1 resets the low counter (no new event).
REQ-020 SHALL ignore a sensor high for fewer than DEBOUNCE synchronized samples (no event).
REQ-021 SHALL generate exactly one event per accepted high level, regardless of how long it lasts.
REQ-022 COUNT/flags SHALL update on the same edge the FSM enters HELD: DEBOUNCE+2 rising edges after the first edge sampling SI/SO high.
REQ-023 entry only, COUNT<CAPACITY: COUNT+1.
REQ-024 entry only, COUNT==CAPACITY: COUNT unchanged; Reject=1 for one cycle.
REQ-025 exit only, COUNT>0: COUNT-1.
REQ-026 exit only, COUNT==0: COUNT unchanged; Underflow=1 for one cycle.
REQ-027 entry and exit in the same cycle: COUNT unchanged; no Reject or Underflow, including at full and empty.
REQ-028 COUNT SHALL never wrap; arithmetic saturates at 0 and CAPACITY.
REQ-029 Full, Empty, NearFull SHALL be registered from the next COUNT value, so they change on the same edge as COUNT.
REQ-030 Reject and Underflow SHALL be low in every cycle without a qualifying event.

Reset
REQ-031 RST=1 at a rising edge SHALL set COUNT=0, Empty=1, Full=0, NearFull=(NEAR_FULL==0), Reject=0, Underflow=0, clear synchronizers and counters, and put both FSMs in HELD.
REQ-032 A sensor held high through reset release SHALL produce no event until it is low for DEBOUNCE samples and then high again for DEBOUNCE samples.
REQ-033 RST SHALL take priority over any event in the same cycle; a reset mid-pulse discards that pulse.

Verification (CAPACITY=8, NEAR_FULL=6, DEBOUNCE=3)
REQ-034 Reset, then 12 SI pulses of 5 cycles high / 5 low -> COUNT 1..8; NearFull at 6; Full at 8; pulses 9-12 each give one Reject, COUNT stays 8.
REQ-035 From 8, 9 SO pulses (5/5) -> COUNT 7..0; Full drops at 7; NearFull drops at 5; Empty at 0; 9th pulse gives one Underflow.
REQ-036 COUNT=4; SI and SO high together for 5 cycles -> COUNT stays 4, no Reject or Underflow; repeat at COUNT=8 and COUNT=0 with the same result.
REQ-037 SI 2-cycle glitch -> no change; SI high 3 cycles -> +1 exactly DEBOUNCE+2=5 edges after first sample; SI high 40 cycles with a 1-cycle low dip -> single +1.
REQ-038 COUNT=5, SI pulse in progress, RST for 1 cycle while SI stays high -> COUNT=0, Empty=1, no increment until SI is low 3+ cycles and then high 3+ cycles.

Source files
------------

// File: rtl/lift_occupancy_counter.sv
// Lift occupancy counter: synchronised, debounced entry/exit sensors drive a
// saturating occupancy count with registered status flags and error pulses.
module lift_occupancy_counter #(
  parameter int CAPACITY  = 8,
  parameter int CNT_W     = 4,
  parameter int NEAR_FULL = 6,
  parameter int DEBOUNCE  = 3
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             SI,
  input  logic             SO,
  output logic [CNT_W-1:0] COUNT,
  output logic             Full,
  output logic             Empty,
  output logic             NearFull,
  output logic             Reject,
  output logic             Underflow
);

  localparam int              DB_W   = $clog2(DEBOUNCE + 1);
  localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE);
  localparam logic [CNT_W-1:0] CAP   = CNT_W'(CAPACITY);
  localparam logic [CNT_W-1:0] NEAR  = CNT_W'(NEAR_FULL);

  typedef enum logic [1:0] {IDLE, ARM, HELD} deb_state_e;

  // Bit 0 is the entry channel, bit 1 the exit channel.
  logic [1:0] sync1_q, sync2_q;
  logic [1:0] evt;

  // NOTE: non-blocking assignments let sync2_q take the old sync1_q value,
  // giving a true two-flop chain regardless of statement order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {SO, SI};
      sync2_q <= sync1_q;
    end
  end

  for (genvar ch = 0; ch < 2; ch++) begin : g_deb
    deb_state_e      state_q, state_d;
    logic [DB_W-1:0] cnt_q, cnt_d;
    logic [DB_W-1:0] cnt_inc;
    logic            s;
    logic            ev;

    assign s       = sync2_q[ch];
    assign cnt_inc = cnt_q + DB_W'(1);

    always_ff @(posedge CLK) begin
      if (RST) begin
        state_q <= HELD;
        cnt_q   <= '0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
      end
    end

    // The counter holds samples already seen, so a level is accepted on the
    // DEBOUNCE-th consecutive sample rather than one sample later.
    // NOTE: defaults at the top of every always_comb keep each path assigned,
    // so no latches are inferred.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
        IDLE: begin
          if (s) begin
            state_d = (DEBOUNCE == 1) ? HELD : ARM;
            cnt_d   = (DEBOUNCE == 1) ? '0 : DB_W'(1);
          end
        end
        ARM: begin
          if (!s) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (cnt_inc == DB_MAX) begin
            state_d = HELD;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        HELD: begin
          if (s) begin
            cnt_d = '0;
          end else if (cnt_inc == DB_MAX) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    always_comb begin
      ev = 1'b0;
      if (s) begin
        if (state_q == ARM && cnt_inc == DB_MAX) ev = 1'b1;
        if (state_q == IDLE && DEBOUNCE == 1)    ev = 1'b1;
      end
    end

    assign evt[ch] = ev;
  end

  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, empty_q, near_q, reject_q, under_q;
  logic             reject_d, under_d;

  always_comb begin
    count_d  = count_q;
    reject_d = 1'b0;
    under_d  = 1'b0;
    case (evt)
      2'b01: begin
        if (count_q == CAP) reject_d = 1'b1;
        else                count_d  = count_q + CNT_W'(1);
      end
      2'b10: begin
        if (count_q == '0) under_d = 1'b1;
        else               count_d = count_q - CNT_W'(1);
      end
      default: ;
    endcase
  end

  // Flags come from count_d so they move on the same edge as the count.
  always_ff @(posedge CLK) begin
    if (RST) begin
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      near_q   <= (NEAR_FULL == 0);
      reject_q <= 1'b0;
      under_q  <= 1'b0;
    end else begin
      count_q  <= count_d;
      full_q   <= (count_d == CAP);
      empty_q  <= (count_d == '0);
      near_q   <= (count_d >= NEAR);
      reject_q <= reject_d;
      under_q  <= under_d;
    end
  end

  assign COUNT     = count_q;
  assign Full      = full_q;
  assign Empty     = empty_q;
  assign NearFull  = near_q;
  assign Reject    = reject_q;
  assign Underflow = under_q;

endmodule

// File: tb/tb_lift_occupancy_counter.sv
// Directed self-checking bench for lift_occupancy_counter with the default
// parameters (CAPACITY=8, NEAR_FULL=6, DEBOUNCE=3).
module tb_lift_occupancy_counter;

  logic       CLK = 1'b0;
  logic       RST, SI, SO;
  logic [3:0] COUNT;
  logic       Full, Empty, NearFull, Reject, Underflow;

  int n_checks = 0;
  int n_fail   = 0;
  int rej_seen = 0;
  int und_seen = 0;

  lift_occupancy_counter #(
    .CAPACITY (8),
    .CNT_W    (4),
    .NEAR_FULL(6),
    .DEBOUNCE (3)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .SI       (SI),
    .SO       (SO),
    .COUNT    (COUNT),
    .Full     (Full),
    .Empty    (Empty),
    .NearFull (NearFull),
    .Reject   (Reject),
    .Underflow(Underflow)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  // Advance one rising edge and sample 1 time unit later.
  task automatic step();
    @(posedge CLK);
    #1;
    rej_seen += int'(Reject);
    und_seen += int'(Underflow);
  endtask

  task automatic pulse(input logic si, input logic so, input int hi, input int lo);
    rej_seen = 0;
    und_seen = 0;
    SI = si;
    SO = so;
    repeat (hi) step();
    SI = 1'b0;
    SO = 1'b0;
    repeat (lo) step();
  endtask

  initial begin
    int exp_cnt;
    RST = 1'b1;
    SI  = 1'b0;
    SO  = 1'b0;
    repeat (3) step();
    check("rst_count", int'(COUNT), 0);
    check("rst_empty", int'(Empty), 1);
    check("rst_full", int'(Full), 0);
    check("rst_near", int'(NearFull), 0);
    check("rst_reject", int'(Reject), 0);
    check("rst_underflow", int'(Underflow), 0);
    RST = 1'b0;
    repeat (5) step();
    check("idle_count", int'(COUNT), 0);

    // Fill to capacity, then four more entries are rejected.
    for (int i = 1; i <= 12; i++) begin
      pulse(1'b1, 1'b0, 5, 5);
      exp_cnt = (i > 8) ? 8 : i;
      check($sformatf("in%0d_count", i), int'(COUNT), exp_cnt);
      check($sformatf("in%0d_near", i), int'(NearFull), (exp_cnt >= 6) ? 1 : 0);
      check($sformatf("in%0d_full", i), int'(Full), (exp_cnt == 8) ? 1 : 0);
      check($sformatf("in%0d_empty", i), int'(Empty), 0);
      check($sformatf("in%0d_reject", i), rej_seen, (i > 8) ? 1 : 0);
      check($sformatf("in%0d_underflow", i), und_seen, 0);
    end

    // Drain to empty, the ninth exit underflows.
    for (int j = 1; j <= 9; j++) begin
      pulse(1'b0, 1'b1, 5, 5);
      exp_cnt = (j > 8) ? 0 : 8 - j;
      check($sformatf("out%0d_count", j), int'(COUNT), exp_cnt);
      check($sformatf("out%0d_full", j), int'(Full), 0);
      check($sformatf("out%0d_near", j), int'(NearFull), (exp_cnt >= 6) ? 1 : 0);
      check($sformatf("out%0d_empty", j), int'(Empty), (exp_cnt == 0) ? 1 : 0);
      check($sformatf("out%0d_underflow", j), und_seen, (j == 9) ? 1 : 0);
      check($sformatf("out%0d_reject", j), rej_seen, 0);
    end

    // Simultaneous entry and exit at 4, 8 and 0.
    repeat (4) pulse(1'b1, 1'b0, 5, 5);
    check("mid_count", int'(COUNT), 4);
    pulse(1'b1, 1'b1, 5, 5);
    check("both4_count", int'(COUNT), 4);
    check("both4_reject", rej_seen, 0);
    check("both4_underflow", und_seen, 0);
    repeat (4) pulse(1'b1, 1'b0, 5, 5);
    check("pre8_count", int'(COUNT), 8);
    pulse(1'b1, 1'b1, 5, 5);
    check("both8_count", int'(COUNT), 8);
    check("both8_reject", rej_seen, 0);
    check("both8_underflow", und_seen, 0);
    repeat (8) pulse(1'b0, 1'b1, 5, 5);
    check("pre0_count", int'(COUNT), 0);
    pulse(1'b1, 1'b1, 5, 5);
    check("both0_count", int'(COUNT), 0);
    check("both0_reject", rej_seen, 0);
    check("both0_underflow", und_seen, 0);
    check("both0_empty", int'(Empty), 1);

    // Glitch shorter than the debounce window is ignored.
    pulse(1'b1, 1'b0, 2, 6);
    check("glitch_count", int'(COUNT), 0);

    // Minimum accepted pulse: count moves on exactly the fifth edge.
    SI = 1'b1;
    step(); step(); step();
    SI = 1'b0;
    step();
    check("lat_edge4_count", int'(COUNT), 0);
    step();
    check("lat_edge5_count", int'(COUNT), 1);
    check("lat_edge5_empty", int'(Empty), 0);
    repeat (6) step();
    check("lat_after_count", int'(COUNT), 1);

    // Long level with a one-cycle dip counts once.
    SI = 1'b1;
    repeat (20) step();
    SI = 1'b0;
    step();
    SI = 1'b1;
    repeat (19) step();
    SI = 1'b0;
    repeat (6) step();
    check("long_count", int'(COUNT), 2);

    // Reset mid-pulse with the sensor still high.
    repeat (3) pulse(1'b1, 1'b0, 5, 5);
    check("pre_rst_count", int'(COUNT), 5);
    SI = 1'b1;
    repeat (3) step();
    RST = 1'b1;
    step();
    RST = 1'b0;
    check("midrst_count", int'(COUNT), 0);
    check("midrst_empty", int'(Empty), 1);
    check("midrst_near", int'(NearFull), 0);
    repeat (10) step();
    check("held_count", int'(COUNT), 0);
    SI = 1'b0;
    repeat (5) step();
    check("released_count", int'(COUNT), 0);
    pulse(1'b1, 1'b0, 5, 5);
    check("rearm_count", int'(COUNT), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
